// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared constants for the vending controller
package vend_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] CTRL_ONES = 2'b01;
  localparam logic [1:0] CTRL_TENS = 2'b10;

  localparam logic [6:0] COIN5  = 7'd5;
  localparam logic [6:0] COIN10 = 7'd10;

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - BCD to active-low seven-segment decoder with blank
module seg7_decoder
  import vend_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/vending_top.sv
// rtl/vending_top.sv - coin credit, vend/change pulses and muxed display; VEND_BLANK_LEADING_ZERO_EN blanks a zero tens digit
module vending_top
  import vend_pkg::*;
#(
  parameter int PRICE      = 20,
  parameter int MAX_CREDIT = 95,
  parameter int SCAN_DIV   = 1
) (
  input  logic       ck,
  input  logic       reset,
  input  logic       co5,
  input  logic       co10,
  input  logic       pay,
  output logic [6:0] seg,
  output logic [1:0] ctrl,
  output logic       payok,
  output logic       change
);

  localparam logic [6:0] PRICE_C   = 7'(PRICE);
  localparam logic [7:0] MAX_C     = 8'(MAX_CREDIT);
  localparam int         CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  logic          co5_q, co10_q, pay_q;
  logic [6:0]    credit;
  logic          co5_evt, co10_evt, pay_evt;
  logic          vend, give_change;
  logic [6:0]    base, add, credit_nxt;
  logic [7:0]    sum;

  logic [CW-1:0] scan_cnt;
  logic          phase, phase_nxt;
  logic [3:0]    digit;
  logic          blank;
  logic [6:0]    seg_nxt;

  always_comb begin
    co5_evt     = co5  & ~co5_q  & ~reset;
    co10_evt    = co10 & ~co10_q & ~reset;
    pay_evt     = pay  & ~pay_q  & ~reset;
    vend        = pay_evt && (credit >= PRICE_C);
    give_change = vend && (credit > PRICE_C);
    base        = vend ? 7'd0 : credit;
    add         = 7'd0;
    if (co5_evt)  add = add + COIN5;
    if (co10_evt) add = add + COIN10;
    sum         = {1'b0, base} + {1'b0, add};
    // coins that would overshoot the ceiling are rejected as a whole
    credit_nxt  = (sum <= MAX_C) ? sum[6:0] : base;
  end

  // prev flops track the inputs even in reset so a level held across release is not an edge
  always_ff @(posedge ck) begin
    co5_q  <= co5;
    co10_q <= co10;
    pay_q  <= pay;
    if (reset) begin
      credit <= 7'd0;
      payok  <= 1'b0;
      change <= 1'b0;
    end else begin
      credit <= credit_nxt;
      payok  <= vend;
      change <= give_change;
    end
  end

  always_comb begin
    phase_nxt = (scan_cnt == SCAN_LAST) ? ~phase : phase;
    digit     = phase_nxt ? 4'(credit / 7'd10) : 4'(credit % 7'd10);
`ifdef VEND_BLANK_LEADING_ZERO_EN
    blank     = phase_nxt && (credit < 7'd10);
`else
    blank     = 1'b0;
`endif
  end

  seg7_decoder u_dec (
    .bcd   (digit),
    .blank (blank),
    .seg   (seg_nxt)
  );

  always_ff @(posedge ck) begin
    if (reset) begin
      scan_cnt <= '0;
      phase    <= 1'b0;
      ctrl     <= CTRL_ONES;
      seg      <= SEG_0;
    end else begin
      scan_cnt <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + 1'b1;
      phase    <= phase_nxt;
      ctrl     <= phase_nxt ? CTRL_TENS : CTRL_ONES;
      seg      <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_vending_top.sv
// tb/tb_vending_top.sv - table-driven scoreboard bench for vending_top
module tb_vending_top;

  logic       ck = 1'b0;
  logic       reset, co5, co10, pay;
  logic [6:0] seg;
  logic [1:0] ctrl;
  logic       payok, change;

  vending_top #(.PRICE(20), .MAX_CREDIT(95), .SCAN_DIV(1)) dut (
    .ck(ck), .reset(reset), .co5(co5), .co10(co10), .pay(pay),
    .seg(seg), .ctrl(ctrl), .payok(payok), .change(change)
  );

  always #5 ck = ~ck;

  typedef struct {
    bit c5, c10, p;
    bit pok, chg;
    int credit;
  } vec_t;

  typedef struct packed {
    logic       pok, chg;
    logic [6:0] seg;
    logic [1:0] ctrl;
  } exp_t;

  vec_t       vecs[$];
  exp_t       sb[$];
  logic [6:0] segs [10];
  int         checks = 0;
  int         failures = 0;
  int         m_credit = 0;
  bit         m_phase = 1'b0;

  function automatic logic [6:0] seg_ref(int cr, bit tens);
    int d;
    d = tens ? cr / 10 : cr % 10;
`ifdef VEND_BLANK_LEADING_ZERO_EN
    if (tens && d == 0) return 7'b1111111;
`endif
    return segs[d];
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s step %0d: got %0h, required %0h", name, idx, act, req);
    end
  endtask

  task automatic add_vec(input bit c5, input bit c10, input bit p,
                         input bit pok, input bit chg, input int cr);
    vec_t v;
    v.c5 = c5; v.c10 = c10; v.p = p; v.pok = pok; v.chg = chg; v.credit = cr;
    vecs.push_back(v);
  endtask

  task automatic step(input int idx, input bit r, input bit c5, input bit c10, input bit p,
                      input bit pok, input bit chg, input int cr);
    exp_t e;
    reset = r; co5 = c5; co10 = c10; pay = p;
    if (r) begin
      m_phase = 1'b0;
      e.pok = 1'b0; e.chg = 1'b0; e.seg = 7'b1000000; e.ctrl = 2'b01;
      m_credit = 0;
    end else begin
      m_phase = ~m_phase;
      e.pok = pok; e.chg = chg;
      e.seg = seg_ref(m_credit, m_phase);
      e.ctrl = m_phase ? 2'b10 : 2'b01;
      m_credit = cr;
    end
    sb.push_back(e);
    @(posedge ck);
    #1;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty step %0d: got 0 entries, required 1", idx);
    end else begin
      e = sb.pop_front();
      chk("payok", idx, int'(payok), int'(e.pok));
      chk("change", idx, int'(change), int'(e.chg));
      chk("ctrl", idx, int'(ctrl), int'(e.ctrl));
      chk("seg", idx, int'(seg), int'(e.seg));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    segs = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    add_vec(0,0,0, 0,0, 0);
    add_vec(0,0,0, 0,0, 0);
    for (int i = 0; i < 5; i++) add_vec(1,0,0, 0,0, 5);
    add_vec(0,0,0, 0,0, 5);
    for (int i = 0; i < 5; i++) add_vec(0,1,0, 0,0, 15);
    add_vec(0,0,0, 0,0, 15);
    add_vec(0,0,1, 0,0, 15);
    add_vec(0,0,1, 0,0, 15);
    add_vec(0,0,0, 0,0, 15);
    for (int i = 0; i < 5; i++) add_vec(0,1,0, 0,0, 25);
    add_vec(0,0,0, 0,0, 25);
    add_vec(0,0,1, 1,1, 0);
    add_vec(0,0,0, 0,0, 0);
    add_vec(1,1,0, 0,0, 15);
    add_vec(0,0,0, 0,0, 15);
    add_vec(1,0,0, 0,0, 20);
    add_vec(0,0,0, 0,0, 20);
    add_vec(1,0,1, 1,0, 5);
    add_vec(0,0,0, 0,0, 5);
    add_vec(1,0,0, 0,0, 10);
    add_vec(0,0,0, 0,0, 10);
    for (int i = 1; i <= 8; i++) begin
      add_vec(0,1,0, 0,0, 10 + 10 * i);
      add_vec(0,0,0, 0,0, 10 + 10 * i);
    end
    add_vec(0,1,0, 0,0, 90);
    add_vec(0,0,0, 0,0, 90);
    add_vec(1,0,0, 0,0, 95);
    add_vec(0,0,0, 0,0, 95);
    add_vec(1,0,0, 0,0, 95);
    add_vec(0,0,0, 0,0, 95);
    add_vec(0,1,0, 0,0, 95);
    add_vec(0,0,0, 0,0, 95);
    add_vec(0,0,0, 0,0, 95);
    add_vec(0,0,1, 1,1, 0);
    add_vec(0,0,0, 0,0, 0);
    add_vec(0,1,0, 0,0, 10);
    add_vec(0,0,0, 0,0, 10);
    add_vec(0,1,0, 0,0, 20);
    add_vec(0,0,0, 0,0, 20);
    add_vec(0,0,1, 1,0, 0);
    add_vec(0,0,0, 0,0, 0);

    reset = 1'b1; co5 = 1'b0; co10 = 1'b0; pay = 1'b0;
    repeat (3) @(posedge ck);
    #1;
    reset = 1'b0;
    chk("reset_payok", 0, int'(payok), 0);
    chk("reset_change", 0, int'(change), 0);
    chk("reset_ctrl", 0, int'(ctrl), 1);
    chk("reset_seg", 0, int'(seg), int'(7'b1000000));

    foreach (vecs[i])
      step(i + 1, 1'b0, vecs[i].c5, vecs[i].c10, vecs[i].p,
           vecs[i].pok, vecs[i].chg, vecs[i].credit);

    // mid-run reset: a pay edge inside reset must not vend, a coin held across release must not count
    step(200, 0, 0,1,0, 0,0, 10);
    step(201, 0, 0,0,0, 0,0, 10);
    step(202, 0, 0,1,0, 0,0, 20);
    step(203, 0, 0,0,0, 0,0, 20);
    step(204, 0, 1,0,0, 0,0, 25);
    step(205, 0, 0,0,0, 0,0, 25);
    step(206, 1, 0,0,1, 0,0, 0);
    step(207, 1, 1,0,0, 0,0, 0);
    step(208, 0, 1,0,0, 0,0, 0);
    step(209, 0, 1,0,0, 0,0, 0);
    step(210, 0, 0,0,0, 0,0, 0);
    step(211, 0, 0,0,0, 0,0, 0);
    step(212, 0, 1,0,0, 0,0, 5);
    step(213, 0, 0,0,0, 0,0, 5);
    step(214, 0, 0,0,0, 0,0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
